// File: rtl/rtc_bus_responder.sv
// RTC side of the multiplexed AD/CS/RD/WR bus: strobe oversampling, register map,
// read-back drive and a prescaled BCD seconds/minutes/hours counter.
module rtc_bus_responder #(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned PRESC_W       = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       AD,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic [7:0] addr_reg,
    output logic       busy,
    output logic       proto_err
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR_WR, S_DATA_WR, S_DATA_RD} state_t;

    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v >= lim)
            r = 8'h00;
        else if (v[3:0] >= 4'h9)
            r = {v[7:4] + 4'h1, 4'h0};
        else
            r = {v[7:4], v[3:0] + 4'h1};
        return r;
    endfunction

    state_t state_q, state_d;
    logic [1:0] ad_sync_q, cs_sync_q, rd_sync_q, wr_sync_q;
    logic [7:0] bus_sync1_q, bus_sync2_q, data_hold_q;
    logic ad_s, cs_s, rd_s, wr_s;
    logic [7:0] bus_s;
    logic [7:0] bus_out_q, bus_out_d, addr_q, addr_d, rd_data_s;
    logic bus_oe_q, bus_oe_d, proto_q, proto_d, addr_load_s, reg_wr_s;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic tick_pending_q, tick_pending_d, tick_s, apply_s, seg_commit_s;
    logic [7:0] seg_q, min_q, hora_q, dia_q, mes_q, anno_q, tseg_q, tmin_q, thora_q;
    logic [7:0] seg_d, min_d, hora_d, dia_d, mes_d, anno_d, tseg_d, tmin_d, thora_d;

    assign ad_s  = ad_sync_q[1];
    assign cs_s  = cs_sync_q[1];
    assign rd_s  = rd_sync_q[1];
    assign wr_s  = wr_sync_q[1];
    assign bus_s = bus_sync2_q;

    // Two-flop synchronisers; strobes reset to their inactive level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ad_sync_q   <= 2'b00;
            cs_sync_q   <= 2'b11;
            rd_sync_q   <= 2'b11;
            wr_sync_q   <= 2'b11;
            bus_sync1_q <= 8'h00;
            bus_sync2_q <= 8'h00;
            data_hold_q <= 8'h00;
        end else begin
            ad_sync_q   <= {ad_sync_q[0], AD};
            cs_sync_q   <= {cs_sync_q[0], CS};
            rd_sync_q   <= {rd_sync_q[0], RD};
            wr_sync_q   <= {wr_sync_q[0], WR};
            bus_sync1_q <= bus_in;
            bus_sync2_q <= bus_sync1_q;
            data_hold_q <= (wr_s == 1'b0) ? bus_s : data_hold_q;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; a simultaneous RD+WR under CS wins over everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!cs_s && !rd_s && !wr_s)  state_d = S_IDLE;
                else if (!cs_s && !wr_s)      state_d = ad_s ? S_DATA_WR : S_ADDR_WR;
                else if (!cs_s && !rd_s && ad_s) state_d = S_DATA_RD;
                else                          state_d = S_IDLE;
            end
            S_ADDR_WR, S_DATA_WR: begin
                if (cs_s || wr_s) state_d = S_IDLE;
                else              state_d = state_q;
            end
            S_DATA_RD: begin
                if (cs_s || rd_s) state_d = S_IDLE;
                else              state_d = S_DATA_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, feeding registered outputs.
    always_comb begin
        addr_load_s = (state_q == S_ADDR_WR) && !cs_s && wr_s;
        reg_wr_s    = (state_q == S_DATA_WR) && !cs_s && wr_s;
        proto_d     = (state_q == S_IDLE) && !cs_s && !rd_s && !wr_s;
        bus_oe_d    = (state_d == S_DATA_RD);
        bus_out_d   = bus_oe_d ? rd_data_s : bus_out_q;
        addr_d      = addr_load_s ? data_hold_q : addr_q;
    end

    // Read mux over the register map.
    always_comb begin
        case (addr_q)
            8'h21:   rd_data_s = seg_q;
            8'h22:   rd_data_s = min_q;
            8'h23:   rd_data_s = hora_q;
            8'h24:   rd_data_s = dia_q;
            8'h25:   rd_data_s = mes_q;
            8'h26:   rd_data_s = anno_q;
            8'h41:   rd_data_s = tseg_q;
            8'h42:   rd_data_s = tmin_q;
            8'h43:   rd_data_s = thora_q;
            default: rd_data_s = 8'h00;
        endcase
    end

    // Prescaler and tick deferral; a seconds write restarts the second.
    always_comb begin
        tick_s       = (presc_q == PRESC_W'(TICKS_PER_SEC - 1));
        seg_commit_s = reg_wr_s && (addr_q == 8'h21);
        apply_s      = (tick_s || tick_pending_q) && (state_q == S_IDLE) && cs_s;
        presc_d      = (seg_commit_s || tick_s) ? '0 : presc_q + PRESC_W'(1);
        if (seg_commit_s)  tick_pending_d = 1'b0;
        else if (apply_s)  tick_pending_d = 1'b0;
        else if (tick_s)   tick_pending_d = 1'b1;
        else               tick_pending_d = tick_pending_q;
    end

    // Register map update: bus writes or a BCD advance (never both in one cycle).
    always_comb begin
        seg_d = seg_q;   min_d = min_q;   hora_d = hora_q;
        dia_d = dia_q;   mes_d = mes_q;   anno_d = anno_q;
        tseg_d = tseg_q; tmin_d = tmin_q; thora_d = thora_q;
        if (reg_wr_s) begin
            case (addr_q)
                8'h21:   seg_d   = data_hold_q;
                8'h22:   min_d   = data_hold_q;
                8'h23:   hora_d  = data_hold_q;
                8'h24:   dia_d   = data_hold_q;
                8'h25:   mes_d   = data_hold_q;
                8'h26:   anno_d  = data_hold_q;
                8'h41:   tseg_d  = data_hold_q;
                8'h42:   tmin_d  = data_hold_q;
                8'h43:   thora_d = data_hold_q;
                default: seg_d   = seg_q;
            endcase
        end else if (apply_s) begin
            seg_d = bcd_next(seg_q, 8'h59);
            if (seg_q >= 8'h59) begin
                min_d = bcd_next(min_q, 8'h59);
                if (min_q >= 8'h59) hora_d = bcd_next(hora_q, 8'h23);
                else                hora_d = hora_q;
            end else begin
                min_d = min_q;
            end
        end else begin
            seg_d = seg_q;
        end
    end

    // Output, prescaler and register-map flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_out_q <= 8'h00;  bus_oe_q <= 1'b0;  addr_q <= 8'h00;  proto_q <= 1'b0;
            presc_q <= '0;       tick_pending_q <= 1'b0;
            seg_q <= 8'h00;  min_q <= 8'h00;  hora_q <= 8'h00;
            dia_q <= 8'h00;  mes_q <= 8'h00;  anno_q <= 8'h00;
            tseg_q <= 8'h00; tmin_q <= 8'h00; thora_q <= 8'h00;
        end else begin
            bus_out_q <= bus_out_d;  bus_oe_q <= bus_oe_d;  addr_q <= addr_d;  proto_q <= proto_d;
            presc_q <= presc_d;      tick_pending_q <= tick_pending_d;
            seg_q <= seg_d;   min_q <= min_d;   hora_q <= hora_d;
            dia_q <= dia_d;   mes_q <= mes_d;   anno_q <= anno_d;
            tseg_q <= tseg_d; tmin_q <= tmin_d; thora_q <= thora_d;
        end
    end

    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign addr_reg  = addr_q;
    assign proto_err = proto_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a 10-cycle second and 10 ns clock.
module tb_rtc_bus_responder;

    logic       clock, reset, AD, CS, RD, WR;
    logic [7:0] bus_in, bus_out, addr_reg;
    logic       bus_oe, busy, proto_err;
    int         checks, errors;

    rtc_bus_responder #(.TICKS_PER_SEC(10), .PRESC_W(32)) dut (
        .clock(clock), .reset(reset), .AD(AD), .CS(CS), .RD(RD), .WR(WR),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .addr_reg(addr_reg),
        .busy(busy), .proto_err(proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic cs_low();
        CS = 1'b0;
        cycle(2);
    endtask

    task automatic cs_high();
        CS = 1'b1;
        cycle(3);
    endtask

    task automatic wr_pulse(input logic ad, input logic [7:0] val);
        AD = ad;
        bus_in = val;
        cycle(1);
        WR = 1'b0;
        cycle(4);
        WR = 1'b1;
        cycle(4);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        cs_low();
        wr_pulse(1'b0, a);
        wr_pulse(1'b1, d);
        cs_high();
    endtask

    // Address phase then an 8-cycle RD pulse, checking data and bus_oe timing.
    task automatic reg_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] got;
        cs_low();
        wr_pulse(1'b0, a);
        AD = 1'b1;
        RD = 1'b0;
        cycle(2);
        chk({tag, "_oe_pre"}, {31'd0, bus_oe}, 32'd0);
        cycle(1);
        chk({tag, "_oe_rise"}, {31'd0, bus_oe}, 32'd1);
        cycle(5);
        got = bus_out;
        chk({tag, "_data"}, {24'd0, got}, {24'd0, exp});
        RD = 1'b1;
        cycle(2);
        chk({tag, "_oe_hold"}, {31'd0, bus_oe}, 32'd1);
        cycle(1);
        chk({tag, "_oe_fall"}, {31'd0, bus_oe}, 32'd0);
        chk({tag, "_keep"}, {24'd0, bus_out}, {24'd0, exp});
        cs_high();
    endtask

    initial begin
        int pe_cnt;
        logic oe_seen, busy_seen;
        checks = 0;
        errors = 0;
        reset = 1'b1; CS = 1'b1; RD = 1'b1; WR = 1'b1; AD = 1'b0; bus_in = 8'h00;
        cycle(3);
        chk("rst_bus_out", {24'd0, bus_out}, 32'd0);
        chk("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("rst_addr", {24'd0, addr_reg}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_proto", {31'd0, proto_err}, 32'd0);
        reset = 1'b0;
        cycle(2);

        // Basic write then read of minutes
        reg_write(8'h22, 8'h45);
        chk("wr_addr", {24'd0, addr_reg}, 32'h22);
        reg_read(8'h22, 8'h45, "rd_min");
        chk("no_autoinc", {24'd0, addr_reg}, 32'h22);

        // Asynchronous reset in the middle of a driven read
        cs_low();
        wr_pulse(1'b0, 8'h22);
        AD = 1'b1;
        RD = 1'b0;
        cycle(4);
        chk("midrd_oe", {31'd0, bus_oe}, 32'd1);
        chk("midrd_data", {24'd0, bus_out}, 32'h45);
        #2 reset = 1'b1;
        #1;
        chk("arst_oe", {31'd0, bus_oe}, 32'd0);
        chk("arst_data", {24'd0, bus_out}, 32'd0);
        chk("arst_addr", {24'd0, addr_reg}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        RD = 1'b1; CS = 1'b1; AD = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        reg_read(8'h21, 8'h00, "rd_seg_after_rst");

        // Full rollover 23:59:59 -> 00:00:00, date untouched
        reg_write(8'h24, 8'h31);
        reg_write(8'h23, 8'h23);
        reg_write(8'h22, 8'h59);
        reg_write(8'h21, 8'h59);
        cycle(10);
        reg_read(8'h21, 8'h00, "roll_seg");
        reg_read(8'h22, 8'h00, "roll_min");
        reg_read(8'h23, 8'h00, "roll_hora");
        reg_read(8'h24, 8'h31, "roll_dia");

        // Two tick points under CS low collapse into one deferred advance
        reg_write(8'h21, 8'h10);
        CS = 1'b0;
        cycle(25);
        CS = 1'b1;
        cycle(3);
        reg_read(8'h21, 8'h11, "defer_seg");

        // RD and WR low together under CS
        AD = 1'b1; bus_in = 8'h99; CS = 1'b0; RD = 1'b0; WR = 1'b0;
        cycle(1);
        CS = 1'b1; RD = 1'b1; WR = 1'b1;
        pe_cnt = 0; oe_seen = 1'b0; busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(1);
            pe_cnt += int'(proto_err);
            oe_seen |= bus_oe;
            busy_seen |= busy;
        end
        chk("proto_pulses", pe_cnt, 32'd1);
        chk("proto_oe", {31'd0, oe_seen}, 32'd0);
        chk("proto_busy", {31'd0, busy_seen}, 32'd0);
        chk("proto_addr", {24'd0, addr_reg}, 32'h21);

        // CS rising before WR aborts the address phase
        AD = 1'b0; bus_in = 8'h55; CS = 1'b0; WR = 1'b0;
        cycle(4);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        CS = 1'b1;
        cycle(3);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        WR = 1'b1;
        cycle(3);
        chk("abort_addr", {24'd0, addr_reg}, 32'h21);

        // Unmapped address ignores writes; timer register holds still
        reg_write(8'h30, 8'h77);
        chk("unmap_addr", {24'd0, addr_reg}, 32'h30);
        reg_read(8'h30, 8'h00, "unmap_rd");
        reg_write(8'h41, 8'h12);
        cycle(25);
        reg_read(8'h41, 8'h12, "tseg_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Synthesizable model of the RTC end of the multiplexed AD/CS/RD/WR bus that Controlador_RTC_PB drives.
- Oversamples the four strobes and decodes address and data write cycles and read cycles.
- Holds the time/date/timer register map, drives read data back, and advances BCD time from a prescaled tick.
- Instantiated beside the controller in system simulation and on-board loopback tests.

Parameters:
- TICKS_PER_SEC, 100000000: clock cycles per one-second tick (min 2).
- PRESC_W, 32: prescaler counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- AD  in  1  0 = address phase, 1 = data phase.
- CS  in  1  chip select, active low.
- RD  in  1  read strobe, active low.
- WR  in  1  write strobe, active low.
- bus_in  in  8  bus value as seen by the RTC.
- bus_out  out  8  read data.
- bus_oe  out  1  1 = RTC drives the bus.
- addr_reg  out  8  latched register address.
- busy  out  1  1 while FSM is not IDLE.
- proto_err  out  1  one-cycle pulse when RD and WR are both low under CS.

Behaviour:
- Sync: AD, CS, RD, WR and bus_in each pass through 2 flops. All decode uses the synced copies (ad_s, cs_s, rd_s, wr_s, bus_s). While wr_s=0, bus_s is captured every cycle into data_hold.
- Reset (asynchronous, clears immediately):
  - bus_out=0x00, bus_oe=0, addr_reg=0x00, busy=0, proto_err=0, FSM=IDLE.
  - All map registers 0x00; prescaler 0; tick_pending 0.
- Register map; other addresses read 0x00 and ignore writes:
  - 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 anno.
  - 0x41 tseg, 0x42 tmin, 0x43 thora.
- FSM states: IDLE, ADDR_WR, DATA_WR, DATA_RD.
- IDLE transitions, evaluated in this order:
  - cs_s=0 & rd_s=0 & wr_s=0: pulse proto_err, stay IDLE.
  - cs_s=0 & wr_s=0: go to ADDR_WR if ad_s=0, else DATA_WR.
  - cs_s=0 & rd_s=0 & ad_s=1: go to DATA_RD.
  - rd_s=0 with ad_s=0: ignored.
- ADDR_WR: on wr_s=1 with cs_s=0, addr_reg<=data_hold, go to IDLE. If cs_s=1 first, abort to IDLE with no update.
- DATA_WR: on wr_s=1 with cs_s=0, reg[addr_reg]<=data_hold if mapped, go to IDLE. cs_s=1 first aborts to IDLE.
- DATA_RD:
  - bus_out<=reg[addr_reg] every cycle (0x00 if unmapped); bus_oe=1.
  - On rd_s=1 or cs_s=1: bus_oe<=0, go to IDLE.
  - bus_oe rises 3 clocks after RD falls and falls 3 clocks after RD rises.
  - bus_out keeps its last value after bus_oe drops.
- addr_reg is not auto-incremented.
- busy = (state != IDLE).
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 and wraps; the wrap cycle raises tick.
  - If tick occurs while busy=1 or cs_s=0, set tick_pending. Apply the pending tick on the first cycle with state=IDLE and cs_s=1, then clear it.
- BCD increment per tick, applied to seg with carry chain seg -> min -> hora:
  - value >= limit (0x59 for seg/min, 0x23 for hora) -> 0x00 plus carry.
  - else low nibble >= 9 -> {high+1, 0}.
  - else low+1.
  - hora wraps 0x23 -> 0x00 without touching dia. Date and timer registers never self-update.
- Write/tick collision: a DATA_WR commit to 0x21 clears the prescaler and tick_pending. If a tick coincides with that commit, the write wins.
- Non-BCD values are stored verbatim.

Test Plan (TICKS_PER_SEC=10, 10 ns clock):
- Reset: assert reset mid-read with bus_oe=1 -> bus_oe=0 and bus_out=0x00 in the same cycle. After release, reading 0x21 returns 0x00.
- Write/read: AD=0/WR pulse with 0x22, then AD=1/WR pulse with 0x45, then RD low for 8 cycles -> addr_reg=0x22; bus_oe high from cycle 3 after RD falls; bus_out=0x45.
- Rollover: write hora=0x23, min=0x59, seg=0x59, wait 10 cycles idle -> seg=0x00, min=0x00, hora=0x00, dia unchanged.
- Deferred tick: hold CS low 25 cycles spanning two tick points -> seg advances by 1 only, on the first idle cycle after CS rises.
- Protocol error: CS=0, RD=0 and WR=0 together -> one proto_err pulse, no register change, bus_oe stays 0.
- Abort and unmapped: CS rises before WR in ADDR_WR -> addr_reg unchanged. Write 0x77 to address 0x30 -> read 0x30 returns 0x00.
